// File: rtl/aurora_fpga_ctrl.sv
// Aurora user-side controller: link bring-up FSM with a settle period, a
// single-register AXI-stream TX stage fed from a FWFT FIFO, and a registered RX FIFO writer.
module aurora_fpga_ctrl #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        user_clk,
  input  logic        rst,
  input  logic        pll_not_locked,
  input  logic        rx_fifo_rst,
  input  logic        channel_rdy,
  input  logic [31:0] fifo_dat_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_o,
  output logic [31:0] fifo_wr_dat_o,
  output logic        fifo_wr_o,
  input  logic        fifo_full_i,
  output logic [0:31] tx_data,
  output logic        tx_data_src_rdy,
  input  logic        tx_data_dst_rdy,
  input  logic [0:31] rx_data,
  input  logic        rx_data_src_rdy
);

  localparam int CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    DOWN   = 2'd0,
    SETTLE = 2'd1,
    UP     = 2'd2
  } linkState_e;

  logic            srst;
  linkState_e      linkState_q, linkState_d;
  logic [CntW-1:0] settleCnt_q, settleCnt_d;
  logic            isUp;
  logic            txLoad;
  logic [0:31]     txData_q, txData_d;
  logic            txValid_q, txValid_d;
  logic [31:0]     wrDat_q;
  logic            wr_q, wr_d;

  assign srst = rst | pll_not_locked;
  assign isUp = (linkState_q == UP);

  // Losing channel_rdy always wins; the counter is only meaningful in SETTLE.
  always_comb begin
    linkState_d = linkState_q;
    settleCnt_d = settleCnt_q;
    if (!channel_rdy) begin
      linkState_d = DOWN;
      settleCnt_d = '0;
    end else begin
      case (linkState_q)
        DOWN: begin
          linkState_d = SETTLE;
          settleCnt_d = '0;
        end
        SETTLE: begin
          if (settleCnt_q == CntLast) linkState_d = UP;
          else                        settleCnt_d = settleCnt_q + 1'b1;
        end
        UP:      linkState_d = UP;
        default: linkState_d = DOWN;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (srst) begin
      linkState_q <= DOWN;
      settleCnt_q <= '0;
    end else begin
      linkState_q <= linkState_d;
      settleCnt_q <= settleCnt_d;
    end
  end

  // The [31:0] -> [0:31] assignment mirrors the bus bit order by position.
  always_comb begin
    txLoad    = isUp & ~fifo_empty_i & (~txValid_q | tx_data_dst_rdy) & ~srst;
    txData_d  = txLoad ? fifo_dat_i : txData_q;
    txValid_d = txValid_q;
    if (txLoad)               txValid_d = 1'b1;
    else if (tx_data_dst_rdy) txValid_d = 1'b0;
    if (linkState_d != UP)    txValid_d = 1'b0;
    wr_d = rx_data_src_rdy & isUp & ~fifo_full_i & ~rx_fifo_rst;
  end

  always_ff @(posedge user_clk) begin
    if (srst) begin
      txData_q  <= '0;
      txValid_q <= 1'b0;
      wrDat_q   <= '0;
      wr_q      <= 1'b0;
    end else begin
      txData_q  <= txData_d;
      txValid_q <= txValid_d;
      wrDat_q   <= rx_data;
      wr_q      <= wr_d;
    end
  end

  // Write strobe is masked by srst so a word captured just before reset never lands.
  assign fifo_rd_o       = txLoad;
  assign tx_data         = txData_q;
  assign tx_data_src_rdy = txValid_q;
  assign fifo_wr_dat_o   = wrDat_q;
  assign fifo_wr_o       = wr_q & ~srst;

endmodule

// File: tb/tb_aurora_fpga_ctrl.sv
// Directed bench for aurora_fpga_ctrl: vector table for steady-state TX/RX behaviour
// plus hand-written sequences for link settle, link drop and reset pulses.
module tb_aurora_fpga_ctrl;

  logic        user_clk;
  logic        rst;
  logic        pll_not_locked;
  logic        rx_fifo_rst;
  logic        channel_rdy;
  logic [31:0] fifo_dat_i;
  logic        fifo_empty_i;
  logic        fifo_rd_o;
  logic [31:0] fifo_wr_dat_o;
  logic        fifo_wr_o;
  logic        fifo_full_i;
  logic [0:31] tx_data;
  logic        tx_data_src_rdy;
  logic        tx_data_dst_rdy;
  logic [0:31] rx_data;
  logic        rx_data_src_rdy;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    string       name;
    logic        ch;
    logic        empty;
    logic [31:0] dat;
    logic        tready;
    logic        rxv;
    logic [31:0] rxDat;
    logic        full;
    logic        rxRst;
    logic        expRd;
    logic        expValid;
    logic [31:0] expTx;
    logic        expWr;
    logic [31:0] expWrDat;
  } vec_t;

  localparam int NumVec = 23;
  vec_t vecs [NumVec];

  aurora_fpga_ctrl #(.SETTLE_CYCLES(16)) dut (
    .user_clk        (user_clk),
    .rst             (rst),
    .pll_not_locked  (pll_not_locked),
    .rx_fifo_rst     (rx_fifo_rst),
    .channel_rdy     (channel_rdy),
    .fifo_dat_i      (fifo_dat_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rd_o       (fifo_rd_o),
    .fifo_wr_dat_o   (fifo_wr_dat_o),
    .fifo_wr_o       (fifo_wr_o),
    .fifo_full_i     (fifo_full_i),
    .tx_data         (tx_data),
    .tx_data_src_rdy (tx_data_src_rdy),
    .tx_data_dst_rdy (tx_data_dst_rdy),
    .rx_data         (rx_data),
    .rx_data_src_rdy (rx_data_src_rdy)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge user_clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    channel_rdy     = v.ch;
    fifo_empty_i    = v.empty;
    fifo_dat_i      = v.dat;
    tx_data_dst_rdy = v.tready;
    rx_data_src_rdy = v.rxv;
    rx_data         = v.rxDat;
    fifo_full_i     = v.full;
    rx_fifo_rst     = v.rxRst;
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal({v.name, ".fifo_rd_o"},       {31'd0, fifo_rd_o},       {31'd0, v.expRd});
    checkVal({v.name, ".tx_data_src_rdy"}, {31'd0, tx_data_src_rdy}, {31'd0, v.expValid});
    checkVal({v.name, ".tx_data"},         tx_data,                  v.expTx);
    checkVal({v.name, ".fifo_wr_o"},       {31'd0, fifo_wr_o},       {31'd0, v.expWr});
    checkVal({v.name, ".fifo_wr_dat_o"},   fifo_wr_dat_o,            v.expWrDat);
  endtask

  // Entered at the start of cycle 0 (first cycle with channel_rdy high); leaves after cycle 17's check.
  task automatic settleCheck(input string name);
    for (int k = 0; k <= 16; k++) begin
      @(negedge user_clk);
      checkVal($sformatf("%s.rd_c%0d", name, k), {31'd0, fifo_rd_o}, 32'd0);
      nextCycle();
    end
    @(negedge user_clk);
    checkVal({name, ".rd_c17"}, {31'd0, fifo_rd_o}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"idle",      1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h0};
    vecs[1]  = '{"tx_w0",     1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 1'b0, 32'h0};
    vecs[2]  = '{"tx_w1",     1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{"tx_show1",  1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b0, 32'h0};
    vecs[4]  = '{"tx_drain",  1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 32'h0};
    vecs[5]  = '{"stall_ld",  1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h00000001, 1'b0, 32'h0};
    for (int i = 6; i <= 10; i++)
      vecs[i] = '{$sformatf("stall%0d", i - 6), 1'b1, 1'b0, 32'h0BADC0DE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{"stall_rel", 1'b1, 1'b0, 32'h0BADC0DE, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[12] = '{"stall_nxt", 1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADC0DE, 1'b0, 32'h0};
    vecs[13] = '{"stall_end", 1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0};
    vecs[14] = '{"rx_pulse",  1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0};
    vecs[15] = '{"rx_write",  1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b1, 32'h12345678};
    vecs[16] = '{"rx_full",   1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0};
    vecs[17] = '{"rx_fdrop",  1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h12345678};
    vecs[18] = '{"rx_rst",    1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 32'h87654321, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0};
    vecs[19] = '{"rx_rdrop",  1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h87654321};
    vecs[20] = '{"rx_again",  1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0};
    vecs[21] = '{"rx_write2", 1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b1, 32'hA5A5A5A5};
    vecs[22] = '{"rx_idle",   1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0};

    rst             = 1'b1;
    pll_not_locked  = 1'b0;
    rx_fifo_rst     = 1'b0;
    channel_rdy     = 1'b0;
    fifo_dat_i      = 32'hA5A5A5A5;
    fifo_empty_i    = 1'b0;
    fifo_full_i     = 1'b0;
    tx_data_dst_rdy = 1'b1;
    rx_data         = 32'h0;
    rx_data_src_rdy = 1'b0;

    nextCycle();
    @(negedge user_clk);
    checkVal("reset.fifo_rd_o",       {31'd0, fifo_rd_o},       32'd0);
    checkVal("reset.tx_data_src_rdy", {31'd0, tx_data_src_rdy}, 32'd0);
    checkVal("reset.tx_data",         tx_data,                  32'd0);
    checkVal("reset.fifo_wr_o",       {31'd0, fifo_wr_o},       32'd0);
    checkVal("reset.fifo_wr_dat_o",   fifo_wr_dat_o,            32'd0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("[TB] link bring-up with non-empty FIFO");
    channel_rdy = 1'b1;
    fifo_dat_i  = 32'h11111111;
    settleCheck("bringup");
    checkVal("bringup.valid_c17", {31'd0, tx_data_src_rdy}, 32'd0);
    nextCycle();
    fifo_empty_i = 1'b1;
    @(negedge user_clk);
    checkVal("bringup.valid_c18", {31'd0, tx_data_src_rdy}, 32'd1);
    checkVal("bringup.tx_c18",    tx_data,                  32'h11111111);
    checkVal("bringup.rd_c18",    {31'd0, fifo_rd_o},       32'd0);
    nextCycle();

    $display("[TB] vector table");
    for (int i = 0; i < NumVec; i++) begin
      applyStimulus(vecs[i]);
      @(negedge user_clk);
      checkOutput(vecs[i]);
      nextCycle();
    end

    $display("[TB] channel drop while stalled");
    fifo_empty_i    = 1'b0;
    fifo_dat_i      = 32'h13579BDF;
    tx_data_dst_rdy = 1'b0;
    @(negedge user_clk);
    checkVal("drop.rd_load", {31'd0, fifo_rd_o}, 32'd1);
    nextCycle();
    channel_rdy = 1'b0;
    @(negedge user_clk);
    checkVal("drop.valid_before", {31'd0, tx_data_src_rdy}, 32'd1);
    checkVal("drop.tx_before",    tx_data,                  32'h13579BDF);
    checkVal("drop.rd_stalled",   {31'd0, fifo_rd_o},       32'd0);
    nextCycle();
    rx_data_src_rdy = 1'b1;
    rx_data         = 32'h0F0F0F0F;
    @(negedge user_clk);
    checkVal("drop.valid_after", {31'd0, tx_data_src_rdy}, 32'd0);
    checkVal("drop.rd_down",     {31'd0, fifo_rd_o},       32'd0);
    nextCycle();
    channel_rdy     = 1'b1;
    rx_data_src_rdy = 1'b0;
    rx_data         = 32'h0;
    tx_data_dst_rdy = 1'b1;
    fifo_dat_i      = 32'h2468ACE0;
    #2;
    checkVal("drop.rx_not_up", {31'd0, fifo_wr_o}, 32'd0);
    settleCheck("resettle");
    nextCycle();

    $display("[TB] rst pulse mid-stream");
    rx_data_src_rdy = 1'b1;
    rx_data         = 32'hFFFF0000;
    @(negedge user_clk);
    checkVal("rst.valid_pre", {31'd0, tx_data_src_rdy}, 32'd1);
    checkVal("rst.tx_pre",    tx_data,                  32'h2468ACE0);
    nextCycle();
    rst = 1'b1;
    @(negedge user_clk);
    checkVal("rst.rd_same", {31'd0, fifo_rd_o}, 32'd0);
    checkVal("rst.wr_same", {31'd0, fifo_wr_o}, 32'd0);
    nextCycle();
    rst             = 1'b0;
    rx_data_src_rdy = 1'b0;
    rx_data         = 32'h0;
    #2;
    checkVal("rst.valid_next", {31'd0, tx_data_src_rdy}, 32'd0);
    checkVal("rst.tx_next",    tx_data,                  32'd0);
    checkVal("rst.wr_next",    {31'd0, fifo_wr_o},       32'd0);
    checkVal("rst.wrdat_next", fifo_wr_dat_o,            32'd0);
    settleCheck("rst_settle");
    nextCycle();

    $display("[TB] pll_not_locked pulse mid-stream");
    pll_not_locked = 1'b1;
    @(negedge user_clk);
    checkVal("pll.valid_pre", {31'd0, tx_data_src_rdy}, 32'd1);
    checkVal("pll.rd_same",   {31'd0, fifo_rd_o},       32'd0);
    nextCycle();
    pll_not_locked = 1'b0;
    #2;
    checkVal("pll.valid_next", {31'd0, tx_data_src_rdy}, 32'd0);
    checkVal("pll.tx_next",    tx_data,                  32'd0);
    @(negedge user_clk);
    checkVal("pll.rd_down", {31'd0, fifo_rd_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/aurora_fpga_ctrl.md
AURORA_FPGA_CTRL -- requirements
Module: aurora_fpga_ctrl

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- user_clk  in  1  Aurora user clock, the only clock.
- rst  in  1  Synchronous active-high reset.
- pll_not_locked  in  1  Clock-module PLL unlocked; same effect as rst.
- rx_fifo_rst  in  1  Synchronous; suppresses RX FIFO writes while high.
- channel_rdy  in  1  Aurora CHANNEL_UP.
- fifo_dat_i  in  32 [31:0]  TX source FIFO data, first-word-fall-through (valid while !fifo_empty_i).
- fifo_empty_i  in  1  TX source FIFO empty.
- fifo_rd_o  out  1  TX FIFO read strobe, combinational.
- fifo_wr_dat_o  out  32 [31:0]  RX sink FIFO write data.
- fifo_wr_o  out  1  RX sink FIFO write strobe.
- fifo_full_i  in  1  RX sink FIFO full.
- tx_data  out  32 [0:31]  Aurora AXI-stream TX TDATA.
- tx_data_src_rdy  out  1  TX TVALID.
- tx_data_dst_rdy  in  1  TX TREADY.
- rx_data  in  32 [0:31]  Aurora RX TDATA.
- rx_data_src_rdy  in  1  RX TVALID; no back-pressure is possible.
REQ-003 The block SHALL have one parameter: SETTLE_CYCLES, default 16, the number of cycles with channel_rdy high before data transfer is enabled.

Function
REQ-004 srst SHALL be defined as rst OR pll_not_locked, and all state SHALL be reset by srst on a user_clk edge.
REQ-005 The link state machine SHALL have three states: DOWN, SETTLE and UP.
- DOWN to SETTLE when channel_rdy=1; the counter loads 0.
- SETTLE increments the counter each cycle; SETTLE to UP when the counter reaches SETTLE_CYCLES-1 with channel_rdy still 1.
- Any state to DOWN on the cycle after channel_rdy=0.
REQ-006 The bus bit order SHALL be vector-assignment order: tx_data[0]=fifo_dat_i[31] ... tx_data[31]=fifo_dat_i[0], and fifo_wr_dat_o[31]=rx_data[0] ... fifo_wr_dat_o[0]=rx_data[31].
REQ-007 The TX path SHALL use one output register (tx_data, tx_data_src_rdy). The load condition SHALL be: state==UP AND !fifo_empty_i AND (!tx_data_src_rdy OR tx_data_dst_rdy) AND !srst.
REQ-008 fifo_rd_o SHALL equal the load condition combinationally. On load, the next edge SHALL capture fifo_dat_i into tx_data and set tx_data_src_rdy=1.
REQ-009 If there is no load and tx_data_dst_rdy=1, tx_data_src_rdy SHALL be cleared. tx_data SHALL hold while the output is valid and not accepted; data and valid SHALL be stable until TREADY.
REQ-010 Sustained throughput SHALL be one word per cycle when the FIFO is non-empty and TREADY is held high. Latency from fifo_rd_o to TVALID SHALL be 1 cycle.
REQ-011 On leaving UP, tx_data_src_rdy SHALL be cleared on the next edge and any pending word SHALL be discarded.
REQ-012 RX writes SHALL be registered. On each edge, fifo_wr_dat_o SHALL take rx_data and fifo_wr_o SHALL take: rx_data_src_rdy AND state==UP AND !fifo_full_i AND !rx_fifo_rst.
REQ-013 RX words arriving while fifo_full_i=1, rx_fifo_rst=1, or the state is not UP SHALL be dropped silently.
REQ-014 fifo_rd_o and fifo_wr_o SHALL never assert while srst=1.

Reset
REQ-015 On srst, the following SHALL apply:
- state=DOWN and counter=0.
- tx_data=0 and tx_data_src_rdy=0.
- fifo_wr_o=0 and fifo_wr_dat_o=0.
- fifo_rd_o=0 combinationally.
REQ-016 Reset mid-transfer SHALL drop the TX holding word and any in-flight RX word. After srst deasserts, the block SHALL wait for channel_rdy and the full SETTLE period again.

Verification
REQ-017 channel_rdy rises at cycle 0 with the FIFO non-empty -> fifo_rd_o stays 0 through cycle 16, first asserts at cycle 17, and TVALID=1 at cycle 18.
REQ-018 In UP, FIFO words 0xDEADBEEF and 0x00000001 with TREADY held 1 -> fifo_rd_o high 2 consecutive cycles; tx_data shows each word exactly one cycle, bit order per REQ-006.
REQ-019 In UP, TREADY=0 for 5 cycles with TVALID=1 -> tx_data is stable and fifo_rd_o=0 throughout; TREADY=1 -> next word loads in the same cycle.
REQ-020 rx_data_src_rdy pulses with 0x12345678 in UP -> fifo_wr_o=1 and fifo_wr_dat_o=0x12345678 one cycle later; the same pulse with fifo_full_i=1 or rx_fifo_rst=1 -> no write.
REQ-021 channel_rdy drops while TVALID=1 and TREADY=0 -> TVALID=0 next cycle; re-raise -> full 16-cycle SETTLE before any read.
REQ-022 rst or pll_not_locked pulses mid-stream -> all outputs 0 on the next edge; fifo_rd_o=0 in the same cycle.
